// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcode map, FSM encoding, default width.
package alu_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SETTLE_WAIT = 2'd1,
        RESP        = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_driver_alu_ref_model.sv
// Combinational reference ALU used to cross-check the external ALU's result.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] exp_res
);

    always_comb begin
        exp_res = '0;
        case (op)
            OP_AND:  exp_res = a & b;
            OP_OR:   exp_res = a | b;
            OP_ADD:  exp_res = a + b;
            OP_XOR:  exp_res = a ^ b;
            OP_NOR:  exp_res = ~(a | b);
            OP_SRL:  exp_res = a >> b[4:0];
            OP_SUB:  exp_res = a - b;
            OP_SLT:  exp_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: exp_res = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Drives a combinational ALU from a valid/ready command channel and returns its outputs.
// Optional reference-model cross-check enabled by ALU_SELFCHECK_EN.
//   state       | meaning
//   IDLE        | ready for a command, ALU inputs hold the last operands
//   SETTLE_WAIT | ALU inputs driven, waiting for outputs to settle
//   RESP        | captured response presented until consumer takes it
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [2:0]       ALU_operation,
    input  logic [WIDTH-1:0] res,
    input  logic             zero,
    input  logic             overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] ovf_count
`ifdef ALU_SELFCHECK_EN
    ,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count
`endif
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic             rsp_zero_q, rsp_zero_d, rsp_ovf_q, rsp_ovf_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0] op_count_q, op_count_d, ovf_count_q, ovf_count_d;
    logic             capture, rsp_hs;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rsp_res_d   = rsp_res_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;
        ovf_count_d = ovf_count_q;
        capture     = 1'b0;
        rsp_hs      = 1'b0;
        cmd_ready   = 1'b0;

        case (state_q)
            IDLE: cmd_ready = 1'b1;
            SETTLE_WAIT: begin
                if (cnt_q == '0) begin
                    capture     = 1'b1;
                    rsp_res_d   = res;
                    rsp_zero_d  = zero;
                    rsp_ovf_d   = overflow;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                cmd_ready = rsp_ready;
                if (rsp_ready) begin
                    rsp_hs      = 1'b1;
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (op_count_q != '1) op_count_d = op_count_q + 1'b1;
                    if (rsp_ovf_q && (ovf_count_q != '1)) ovf_count_d = ovf_count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept path is shared by IDLE and the back-to-back case in RESP.
        if (cmd_valid && cmd_ready) begin
            a_d     = cmd_a;
            b_d     = cmd_b;
            op_d    = cmd_op;
            cnt_d   = SETTLE_CNT;
            state_d = SETTLE_WAIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rsp_res_q   <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= '0;
            ovf_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rsp_res_q   <= rsp_res_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign A             = a_q;
    assign B             = b_q;
    assign ALU_operation = op_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_res       = rsp_res_q;
    assign rsp_zero      = rsp_zero_q;
    assign rsp_ovf       = rsp_ovf_q;
    assign op_count      = op_count_q;
    assign ovf_count     = ovf_count_q;

`ifdef ALU_SELFCHECK_EN
    logic [WIDTH-1:0] exp_res;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a       (a_q),
        .b       (b_q),
        .op      (op_q),
        .exp_res (exp_res)
    );

    always_comb begin
        mismatch_d  = mismatch_q;
        err_count_d = err_count_q;
        if (capture) mismatch_d = (res != exp_res) || (zero != (res == '0));
        if (rsp_hs && mismatch_q && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            mismatch_q  <= mismatch_d;
            err_count_q <= err_count_d;
        end
    end

    assign mismatch  = rsp_valid_q & mismatch_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Initiator side of the combinational ALU interface (A, B, ALU_operation -> res, zero, overflow). Accepts operand/opcode commands on a valid/ready channel and registers them onto the ALU input ports. After a fixed settle time it captures the ALU outputs. It returns them on a valid/ready response channel with backpressure, and keeps operation and overflow statistics.

Parameters:
WIDTH, 32, operand/result width (ALU port width)
SETTLE, 1, cycles between driving ALU inputs and sampling ALU outputs (1..15)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept command
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_op  in  3  ALU opcode
A  out  WIDTH  to ALU operand A (registered)
B  out  WIDTH  to ALU operand B (registered)
ALU_operation  out  3  to ALU opcode (registered)
res  in  WIDTH  from ALU result
zero  in  1  from ALU zero flag
overflow  in  1  from ALU overflow flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_res  out  WIDTH  captured result
rsp_zero  out  1  captured zero
rsp_ovf  out  1  captured overflow
op_count  out  CNT_W  completed responses (handshakes)
ovf_count  out  CNT_W  completed responses with rsp_ovf=1

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all registered outputs 0. cmd_ready=1 (state IDLE), rsp_valid=0, counters 0.
- FSM states: IDLE, SETTLE_WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_a/cmd_b/cmd_op into A/B/ALU_operation, load the settle counter with SETTLE, and go to SETTLE_WAIT.
- SETTLE_WAIT:
  - cmd_ready=0.
  - The counter decrements each cycle.
  - In the cycle where the counter reaches 0, sample res/zero/overflow into the rsp_* registers, set rsp_valid=1, and go to RESP.
  - Latency from the accept edge to rsp_valid high is SETTLE+1 cycles (SETTLE=1 gives 2).
- RESP:
  - rsp_valid held high and rsp_* held stable until rsp_ready.
  - On rsp_valid&rsp_ready: increment op_count, and increment ovf_count if rsp_ovf. Then:
    - If cmd_valid is also high in the same cycle, accept the new command directly (cmd_ready=rsp_ready in RESP). Latch it and go to SETTLE_WAIT; rsp_valid drops.
    - Otherwise go to IDLE.
- A/B/ALU_operation change only on command accept. They hold their value through RESP and IDLE, so the ALU output stays stable.
- Counters saturate at all-ones and do not wrap.
- Opcode values are passed through unchecked. All 8 codes are legal.
- rst asserted mid-operation: immediate return to the reset values. Any in-flight command or response is discarded and not counted.
- rsp_valid never depends combinationally on rsp_ready. cmd_ready is combinational only from state and rsp_ready.

Optional Feature:
ALU_SELFCHECK_EN
- Defined: an internal reference model computes the expected result from the latched A/B/op using the package opcode map:
  - 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR
  - 101 SRL (A >> B[4:0])
  - 110 SUB
  - 111 SLT (signed)
- Adds output mismatch (1 bit). It is asserted with rsp_valid when the captured res differs from the expected result or when the captured zero differs from (res==0).
- Adds output err_count (CNT_W), which counts accepted responses with mismatch=1 and saturates.
- Not defined: neither port exists and no model logic is generated.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_AND..OP_SLT
  - FSM state encoding (2-bit)
  - default WIDTH
- One natural sub-module: alu_ref_model, combinational (A, B, op -> exp_res). Instantiated only under ALU_SELFCHECK_EN.

Test Plan:
- A=A5A5A5A5, B=5A5A5A5A, op=010, rsp_ready=1: rsp_res=FFFFFFFF, zero=0, ovf=0. rsp_valid rises 2 cycles after accept (SETTLE=1).
- Same operands, op=000: rsp_res=00000000, rsp_zero=1. op_count=2 after both responses.
- A=7FFFFFFF, B=00000001, op=010: rsp_res=80000000, rsp_ovf=1, ovf_count increments to 1.
- rsp_ready held 0 for 5 cycles with cmd_valid=1:
  - rsp_* stable and cmd_ready=0 throughout.
  - When rsp_ready=1, the next command is accepted in the same cycle.
  - No command is lost or duplicated; op_count is exact.
- rst pulsed while in SETTLE_WAIT: rsp_valid=0, A/B/ALU_operation=0, counters=0, cmd_ready=1 within the reset cycle.
- With ALU_SELFCHECK_EN, connect a faulty ALU that forces res=0 on op=111, then drive A=A5A5A5A5, B=5A5A5A5A: expected 00000001, mismatch=1, err_count=1.
